// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: instruction-sequencing FSM and ALU control for the multicycle RISC-V datapath.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    state_t state, state_nx;
    logic rdy, pc_w, mem_w, ir_w, reg_w, ill;
    logic [1:0] alu_op;
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = FETCH;
        adr_src = 1'b0;
        result_src = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op = 2'b00;
        pc_w = 1'b0;
        mem_w = 1'b0;
        ir_w = 1'b0;
        reg_w = 1'b0;
        ill = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = 2'b10;
                result_src = 2'b10;
                ir_w = rdy;
                pc_w = rdy;
                state_nx = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECUTER;
                    OP_I:         state_nx = EXECUTEI;
                    OP_BEQ:       state_nx = BEQ;
                    OP_JAL:       state_nx = JAL;
                    default:      ill = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nx = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_nx = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op = 2'b10;
                state_nx = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op = 2'b10;
                state_nx = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op = 2'b01;
                pc_w = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_w = 1'b1;
                state_nx = ALUWB;
            end
            default: ;
        endcase
    end
    // Subtract only for R-type with funct7b5; I-type addi always adds.
    assign alu_ctrl = (alu_op == 2'b00) ? 3'b000 :
                      (alu_op == 2'b01) ? 3'b001 :
                      (funct3 == 3'b000) ? {2'b00, opcode[5] & funct7b5} :
                      (funct3 == 3'b010) ? 3'b101 :
                      (funct3 == 3'b110) ? 3'b011 :
                      (funct3 == 3'b111) ? 3'b010 : 3'b000;
    assign imm_src = (opcode == OP_SW)  ? 2'b01 :
                     (opcode == OP_BEQ) ? 2'b10 :
                     (opcode == OP_JAL) ? 2'b11 : 2'b00;
    assign pc_write   = pc_w & rst_n;
    assign mem_write  = mem_w & rst_n;
    assign ir_write   = ir_w & rst_n;
    assign reg_write  = reg_w & rst_n;
    assign illegal_op = ill & rst_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences checked every cycle against a per-phase model.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1110011;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                   P_EX = 6, P_WB = 7, P_BEQ = 8, P_JAL = 9;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    logic [16:0] act_v, exp_v;
    logic valid = 1'b0;
    int exp_p, key_alu;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op)
    );

    assign act_v = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                    alu_src_b, imm_src, reg_write, alu_ctrl, illegal_op};

    // ALU operation implied by the instruction itself: sub/slt/or/and/add
    function automatic logic [2:0] alu_code(logic [6:0] op, logic [2:0] f3, logic f7);
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        if (f3 == 3'd0 && op == RT && f7) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [16:0] model(int p, logic r, logic z, logic [6:0] op,
                                          logic [2:0] f3, logic f7);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sb} = '0;
        ac = 3'b000;
        imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
        if (p == P_F) begin sb = 2; rs = 2; pcw = r; irw = r; end
        if (p == P_D) begin sa = 1; sb = 1; ill = !(op inside {LW, SW, RT, IT, BQ, JL}); end
        if (p == P_MA) begin sa = 2; sb = 1; end
        if (p == P_MR) adr = 1;
        if (p == P_MWB) begin rs = 1; rw = 1; end
        if (p == P_MW) begin adr = 1; mw = 1; end
        if (p == P_EX) begin sa = 2; sb = (op == RT) ? 2'd0 : 2'd1; ac = alu_code(op, f3, f7); end
        if (p == P_WB) rw = 1;
        if (p == P_BEQ) begin sa = 2; ac = 3'b001; pcw = z; end
        if (p == P_JAL) begin sa = 1; sb = 2; pcw = 1; end
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac, ill};
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle phase=%0d op=%b: outputs %h, required %h", exp_p, opcode, act_v, exp_v);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_exp(int p, logic r);
        mem_ready = r;
        exp_p = p;
        exp_v = model(p, r, zero, opcode, funct3, funct7b5);
        valid = 1'b1;
    endtask

    task automatic step(int p, logic r);
        set_exp(p, r);
        #2;
        if (p == P_EX || p == P_BEQ) key_alu = int'(alu_ctrl);
        @(posedge clk);
        #1;
    endtask

    task automatic run(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                       int fst, int mst, int lat, int alu_lit, int cut);
        int ph[$];
        logic rd[$];
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z; key_alu = -1;
        repeat (fst) begin ph.push_back(P_F); rd.push_back(1'b0); end
        ph.push_back(P_F); rd.push_back(1'b1);
        ph.push_back(P_D); rd.push_back(1'b1);
        if (op == LW) begin
            ph.push_back(P_MA); rd.push_back(1'b0);
            repeat (mst) begin ph.push_back(P_MR); rd.push_back(1'b0); end
            ph.push_back(P_MR); rd.push_back(1'b1);
            ph.push_back(P_MWB); rd.push_back(1'b0);
        end else if (op == SW) begin
            ph.push_back(P_MA); rd.push_back(1'b1);
            ph.push_back(P_MW); rd.push_back(1'b0);
        end else if (op == RT || op == IT) begin
            ph.push_back(P_EX); rd.push_back(1'b0);
            ph.push_back(P_WB); rd.push_back(1'b0);
        end else if (op == BQ) begin
            ph.push_back(P_BEQ); rd.push_back(1'b1);
        end else if (op == JL) begin
            ph.push_back(P_JAL); rd.push_back(1'b0);
            ph.push_back(P_WB); rd.push_back(1'b1);
        end
        chk({name, " latency"}, ph.size(), lat);
        for (int i = 0; i < ph.size() && (cut < 0 || i < cut); i++) step(ph[i], rd[i]);
        if (alu_lit >= 0) chk({name, " alu_ctrl"}, key_alu, alu_lit);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b1;
        opcode = SW;
        #12;
        chk("rst pc_write", pc_write, 0);
        chk("rst ir_write", ir_write, 0);
        chk("rst alu_src_b", alu_src_b, 2);
        chk("rst result_src", result_src, 2);
        mem_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("add",  RT, 3'd0, 1'b0, 1'b0, 0, 0, 4, 0, -1);
        run("sub",  RT, 3'd0, 1'b1, 1'b1, 0, 0, 4, 1, -1);
        run("slt",  RT, 3'd2, 1'b0, 1'b0, 0, 0, 4, 5, -1);
        run("or",   RT, 3'd6, 1'b0, 1'b0, 0, 0, 4, 3, -1);
        run("and",  RT, 3'd7, 1'b0, 1'b0, 0, 0, 4, 2, -1);
        run("ori",  IT, 3'd6, 1'b0, 1'b0, 0, 0, 4, 3, -1);
        run("addi", IT, 3'd0, 1'b1, 1'b0, 0, 0, 4, 0, -1);
        run("lw",   LW, 3'd2, 1'b0, 1'b0, 0, 0, 5, -1, -1);
        run("lw_w", LW, 3'd2, 1'b0, 1'b0, 0, 3, 8, -1, -1);
        run("lw_f", LW, 3'd2, 1'b0, 1'b1, 2, 0, 7, -1, -1);
        run("sw",   SW, 3'd2, 1'b0, 1'b0, 0, 0, 4, -1, -1);
        run("beq1", BQ, 3'd0, 1'b0, 1'b1, 0, 0, 3, 1, -1);
        run("beq0", BQ, 3'd0, 1'b0, 1'b0, 0, 0, 3, 1, -1);
        run("ill",  ILL, 3'd0, 1'b0, 1'b0, 0, 0, 2, -1, -1);
        run("jal",  JL, 3'd0, 1'b0, 1'b0, 0, 0, 4, -1, -1);
        run("sw_rst", SW, 3'd2, 1'b0, 1'b0, 0, 0, 4, -1, 3);
        set_exp(P_MW, 1'b0);
        @(negedge clk);
        #2;
        valid = 1'b0;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst mem_write drop", mem_write, 0);
        chk("rst adr_src", adr_src, 0);
        chk("rst ir_write held", ir_write, 0);
        @(posedge clk);
        #3;
        chk("rst pc_write held", pc_write, 0);
        rst_n = 1'b1;
        #1;
        chk("release ir_write", ir_write, 1);
        chk("release pc_write", pc_write, 1);
        chk("release alu_ctrl", alu_ctrl, 0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        run("add2", RT, 3'd0, 1'b0, 1'b0, 1, 0, 5, 0, -1);
        step(P_F, 1'b0);
        valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit: the producer side of the ALU control interface, the other end of the ALU's `alu_ctrl` port.
- Holds the instruction-sequencing FSM. Drives datapath strobes, mux selects and the 3-bit `alu_ctrl` code (000 add, 001 sub, 010 and, 011 or, 101 slt) to the existing ALU.
- Samples the ALU `zero` flag for branch resolution.
- Sits between the instruction register/memory interface and the shared ALU of the multicycle RISC-V datapath.

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEMREAD stall until mem_ready=1; when 0 mem_ready is treated as constant 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory read data valid this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction/old-PC register enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = MDR, 10 = ALUResult.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- alu_ctrl  out  3  ALU operation code.
- illegal_op  out  1  one-cycle pulse, unsupported opcode decoded.

Behaviour:

State register and outputs
- 4-bit state register, async cleared to FETCH on rst_n=0.
- All outputs are combinational from the state register and inputs (Moore, except the qualified strobes noted below).
- While rst_n=0, pc_write, mem_write, ir_write, reg_write and illegal_op are forced 0. Other outputs take their FETCH values.
- Default for every output is 0 / 00 unless listed for the state.
- imm_src is decoded from opcode in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.

ALU decode
- alu_op (internal, 2 bits) is set per state: 00 gives alu_ctrl=000 (add); 01 gives 001 (sub).
- alu_op=10 decodes funct3:
  - 000 → 001 if (opcode[5] & funct7b5), else 000.
  - 010 → 101.
  - 110 → 011.
  - 111 → 010.
  - other funct3 → 000.

States
- FETCH:
  - Outputs: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready (qualified).
  - Next: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target computed into ALUOut).
  - Next by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode → FETCH, with illegal_op=1 for this cycle.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next: opcode 0000011 → MEMREAD, else MEMWRITE.
- MEMREAD:
  - Outputs: result_src=00, adr_src=1.
  - Next: MEMWB if mem_ready, else stay.
- MEMWB:
  - Outputs: result_src=01, reg_write=1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: result_src=00, adr_src=1, mem_write=1. Single cycle; the write is posted and does not wait for mem_ready.
  - Next: FETCH.
- EXECUTER:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next: ALUWB.
- EXECUTEI:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=10. Because opcode[5]=0, funct3=000 always yields add.
  - Next: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1.
  - Next: FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero (same-cycle, combinational).
  - Next: FETCH.
- JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Next: ALUWB (writes PC+4 to rd).

Latency in cycles, excluding wait states
- lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.

Boundary conditions
- Each mem_ready=0 cycle in FETCH/MEMREAD adds exactly one cycle; no strobe fires in that cycle.
- rst_n assertion in any state returns to FETCH immediately. No partial write completes after the asynchronous assertion edge.
- First FETCH is evaluated on the first rising clk after rst_n deasserts.
- Unencoded state values (11–15) → FETCH on the next clk. All outputs take default 0 in those states.

Test Plan:
1. Reset in MEMWRITE: rst_n low mid-cycle → mem_write drops to 0 immediately; state is FETCH; after release, first edge with mem_ready=1 gives ir_write=1, pc_write=1, alu_ctrl=000.
2. add x3,x1,x2 (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 → FETCH→DECODE→EXECUTER→ALUWB. alu_ctrl=000 in EXECUTER; reg_write=1 only in cycle 4. With funct7b5=1 → alu_ctrl=001.
3. lw with mem_ready held 0 for 3 cycles in MEMREAD → MEMREAD held 4 cycles, then MEMWB with reg_write=1, result_src=01; total 8 cycles.
4. beq: zero=1 → pc_write=1 in BEQ with alu_ctrl=001. Repeat with zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
5. slt/or/and R-type with funct3 010/110/111 → alu_ctrl 101/011/010 in EXECUTER. ori (0010011, funct3 110) → 011 with alu_src_b=01.
6. Opcode 1110011 → illegal_op=1 for exactly one cycle in DECODE; no reg_write or mem_write; back in FETCH next cycle. jal → pc_write=1 in JAL, then reg_write=1 in ALUWB.
